// File: rtl/hs32_xu.sv
// hs32_xu: multi-cycle execute unit with register file, ALU, barrel shift,
// load/store sequencing and branch redirect. Optional NZCV flags: HS32_XU_FLAGS_EN.
module hs32_xu #(
    parameter int XLEN = 32,
    parameter int NREG = 16,
    parameter int RW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    output logic            ready,
    input  logic [1:0]      opc,
    input  logic [2:0]      aluop,
    input  logic [4:0]      shift,
    input  logic [15:0]     imm,
    input  logic            simm,
    input  logic            setf,
    input  logic [1:0]      cond,
    input  logic [RW-1:0]   rd,
    input  logic [RW-1:0]   rm,
    input  logic [RW-1:0]   rn,
    output logic [XLEN-1:0] newpc,
    output logic            flush,
    output logic [XLEN-1:0] addr,
    output logic [XLEN-1:0] dtw,
    output logic            rw,
    output logic            reqm,
    input  logic            ackm,
    input  logic [XLEN-1:0] dtrm,
    output logic [3:0]      flags
);

    localparam logic [1:0] OPC_ALU = 2'd0;
    localparam logic [1:0] OPC_LD  = 2'd1;
    localparam logic [1:0] OPC_ST  = 2'd2;
    localparam logic [1:0] OPC_BR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MREQ,
        S_MWAIT
    } state_t;

    state_t          r_state;
    logic [1:0]      r_opc;
    logic [2:0]      r_aluop;
    logic [4:0]      r_shift;
    logic [15:0]     r_imm;
    logic            r_simm;
    logic            r_setf;
    logic [1:0]      r_cond;
    logic [RW-1:0]   r_rd;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_d;
    logic [XLEN-1:0] r_newpc;
    logic            r_flush;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_dtw;
    logic            r_rw;
    logic            r_reqm;
    logic [XLEN-1:0] r_rf [NREG];

    logic [XLEN-1:0] w_bsrc;
    logic [XLEN-1:0] w_bsh;
    logic [XLEN-1:0] w_ea;
    logic [XLEN-1:0] w_bop;
    logic [XLEN-1:0] w_res;
    logic [XLEN:0]   w_sum;
    logic            w_cin;
    logic            w_arith;
    logic            w_cout;
    logic            w_vflag;
    logic            w_cflag;
    logic            w_take;
    logic            w_we;
    logic [XLEN-1:0] w_wd;

    // Operand B: immediate or Rn, then logical left shift
    assign w_bsrc = r_simm ? XLEN'(r_imm) : r_b;
    assign w_bsh  = w_bsrc << r_shift;
    assign w_ea   = r_a + w_bsh;

    // ALU: subtraction is A + ~B + cin so carry means no borrow
    always_comb begin
        w_bop   = w_bsh;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        w_res   = '0;
        case (r_aluop)
            3'd0: w_arith = 1'b1;
            3'd1: begin
                w_bop   = ~w_bsh;
                w_cin   = 1'b1;
                w_arith = 1'b1;
            end
            3'd6: begin
                w_cin   = w_cflag;
                w_arith = 1'b1;
            end
            3'd7: begin
                w_bop   = ~w_bsh;
                w_cin   = w_cflag;
                w_arith = 1'b1;
            end
            default: ;
        endcase
        w_sum = {1'b0, r_a} + {1'b0, w_bop}
              + {{XLEN{1'b0}}, w_cin};
        case (r_aluop)
            3'd2:    w_res = r_a & w_bsh;
            3'd3:    w_res = r_a | w_bsh;
            3'd4:    w_res = r_a ^ w_bsh;
            3'd5:    w_res = w_bsh;
            default: w_res = w_sum[XLEN-1:0];
        endcase
    end

    assign w_cout  = w_sum[XLEN];
    assign w_vflag = (r_a[XLEN-1] == w_bop[XLEN-1])
                  && (w_res[XLEN-1] != r_a[XLEN-1]);

`ifdef HS32_XU_FLAGS_EN
    logic [3:0] r_flags;

    // NZCV update on flag-setting ALU ops; logic ops keep C and V
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= '0;
        end else if (r_state == S_EXEC && r_opc == OPC_ALU && r_setf) begin
            r_flags <= {w_res[XLEN-1],
                        w_res == '0,
                        w_arith ? w_cout  : r_flags[1],
                        w_arith ? w_vflag : r_flags[0]};
        end
    end

    assign w_cflag = r_flags[1];
    assign flags   = r_flags;

    // Branch condition from current flags
    always_comb begin
        w_take = 1'b1;
        case (r_cond)
            2'd1:    w_take = r_flags[2];
            2'd2:    w_take = ~r_flags[2];
            2'd3:    w_take = r_flags[1];
            default: w_take = 1'b1;
        endcase
    end
`else
    logic w_unused;

    assign w_cflag  = 1'b0;
    assign w_take   = 1'b1;
    assign flags    = 4'd0;
    assign w_unused = ^{r_setf, r_cond, w_cout, w_vflag, w_arith};
`endif

    assign w_we = (r_state == S_EXEC && r_opc == OPC_ALU)
               || (r_state == S_MWAIT && ackm && !r_rw);
    assign w_wd = (r_state == S_EXEC) ? w_res : dtrm;

    // Register file write port; cleared on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_we) begin
            r_rf[r_rd] <= w_wd;
        end
    end

    // Control FSM with registered memory and branch outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_opc   <= '0;
            r_aluop <= '0;
            r_shift <= '0;
            r_imm   <= '0;
            r_simm  <= 1'b0;
            r_setf  <= 1'b0;
            r_cond  <= '0;
            r_rd    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_newpc <= '0;
            r_flush <= 1'b0;
            r_addr  <= '0;
            r_dtw   <= '0;
            r_rw    <= 1'b0;
            r_reqm  <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_opc   <= opc;
                        r_aluop <= aluop;
                        r_shift <= shift;
                        r_imm   <= imm;
                        r_simm  <= simm;
                        r_setf  <= setf;
                        r_cond  <= cond;
                        r_rd    <= rd;
                        r_a     <= r_rf[rm];
                        r_b     <= r_rf[rn];
                        r_d     <= r_rf[rd];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_opc)
                        OPC_LD, OPC_ST: begin
                            r_addr  <= w_ea;
                            r_rw    <= (r_opc == OPC_ST);
                            r_dtw   <= r_d;
                            r_reqm  <= 1'b1;
                            r_state <= S_MREQ;
                        end
                        OPC_BR: begin
                            r_newpc <= w_ea;
                            r_flush <= w_take;
                            r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
                S_MREQ: r_state <= S_MWAIT;
                S_MWAIT: begin
                    if (ackm) begin
                        r_reqm  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready = (r_state == S_IDLE) & reset;
    assign newpc = r_newpc;
    assign flush = r_flush;
    assign addr  = r_addr;
    assign dtw   = r_dtw;
    assign rw    = r_rw;
    assign reqm  = r_reqm;

endmodule

// File: tb/tb_hs32_xu.sv
// tb_hs32_xu: directed bench for hs32_xu with a memory-request scoreboard.
// Registers are read back through STORE data (dtw = R[rd]).
module tb_hs32_xu;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic        ready;
    logic [1:0]  opc;
    logic [2:0]  aluop;
    logic [4:0]  shift;
    logic [15:0] imm;
    logic        simm;
    logic        setf;
    logic [1:0]  cond;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [3:0]  rn;
    logic [31:0] newpc;
    logic        flush;
    logic [31:0] addr;
    logic [31:0] dtw;
    logic        rw;
    logic        reqm;
    logic        ackm;
    logic [31:0] dtrm;
    logic [3:0]  flags;

`ifdef HS32_XU_FLAGS_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
    } mreq_t;

    mreq_t       sb[$];
    logic [31:0] m[16];
    int          ncmp = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    hs32_xu dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .ready (ready),
        .opc   (opc),
        .aluop (aluop),
        .shift (shift),
        .imm   (imm),
        .simm  (simm),
        .setf  (setf),
        .cond  (cond),
        .rd    (rd),
        .rm    (rm),
        .rn    (rn),
        .newpc (newpc),
        .flush (flush),
        .addr  (addr),
        .dtw   (dtw),
        .rw    (rw),
        .reqm  (reqm),
        .ackm  (ackm),
        .dtrm  (dtrm),
        .flags (flags)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [2:0] op,
                         input logic [4:0] sh, input logic [15:0] im,
                         input logic s, input logic sf,
                         input logic [1:0] c, input logic [3:0] d,
                         input logic [3:0] a, input logic [3:0] b);
        int t = 0;
        while (!ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ncmp++;
        assert (t < 50) else begin
            nfail++;
            $error("FAIL issue_timeout: observed %0d expected <50", t);
        end
        opc = o; aluop = op; shift = sh; imm = im; simm = s;
        setf = sf; cond = c; rd = d; rm = a; rn = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        chk("ready_busy", 32'(ready), 32'd0);
    endtask

    task automatic alu(input string tag, input logic [2:0] op,
                       input logic [3:0] d, input logic [3:0] a,
                       input logic [3:0] b, input logic [15:0] im,
                       input logic s, input logic [4:0] sh,
                       input logic sf, input logic [31:0] exp);
        issue(2'd0, op, sh, im, s, sf, 2'd0, d, a, b);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        m[d] = exp;
    endtask

    task automatic serve(input string tag, input int waits,
                         input logic [31:0] rdata);
        int hi = 0;
        mreq_t e;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (reqm) begin
                hi++;
                if (hi == 1) begin
                    chk({tag, "_sb_avail"}, 32'(sb.size() > 0), 32'd1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk({tag, "_addr"}, addr, e.a);
                        chk({tag, "_rw"}, 32'(rw), 32'(e.w));
                        chk({tag, "_dtw"}, dtw, e.d);
                    end
                end
                if (hi == waits + 1) begin
                    ackm = 1'b1;
                    dtrm = rdata;
                end
            end else if (hi > 0) begin
                break;
            end
        end
        ackm = 1'b0;
        dtrm = 32'hBAD0BAD0;
        chk({tag, "_reqm_cycles"}, 32'(hi), 32'(waits + 1));
    endtask

    task automatic mem(input string tag, input logic [1:0] o,
                       input logic [3:0] d, input logic [3:0] a,
                       input logic [15:0] im, input int waits,
                       input logic [31:0] rdata, input logic [31:0] ea);
        sb.push_back(mreq_t'{ea, (o == 2'd2), m[d]});
        issue(o, 3'd0, 5'd0, im, 1'b1, 1'b0, 2'd0, d, a, 4'd0);
        serve(tag, waits, rdata);
        if (o == 2'd1) m[d] = rdata;
    endtask

    task automatic rdreg(input string tag, input logic [3:0] r);
        mem(tag, 2'd2, r, 4'd0, 16'd0, 1, 32'h12345678, m[0]);
    endtask

    task automatic branch(input string tag, input logic [1:0] c,
                          input logic [3:0] a, input logic [15:0] im,
                          input logic take, input logic [31:0] ea);
        issue(2'd3, 3'd0, 5'd0, im, 1'b1, 1'b0, c, 4'd0, a, 4'd0);
        chk({tag, "_flush_exec"}, 32'(flush), 32'd0);
        @(negedge clk);
        chk({tag, "_flush"}, 32'(flush), 32'(take));
        chk({tag, "_newpc"}, newpc, ea);
        @(negedge clk);
        chk({tag, "_flush_end"}, 32'(flush), 32'd0);
    endtask

    initial begin
        mreq_t e;
        reset = 1'b0; valid = 1'b0; opc = '0; aluop = '0;
        shift = '0; imm = '0; simm = 1'b0; setf = 1'b0;
        cond = '0; rd = '0; rm = '0; rn = '0;
        ackm = 1'b0; dtrm = 32'hBAD0BAD0;
        foreach (m[i]) m[i] = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_reqm", 32'(reqm), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_newpc", newpc, 32'd0);
        @(negedge clk);

        alu("mov_r3", 3'd5, 4'd3, 4'd0, 4'd0, 16'h1234, 1'b1, 5'd4,
            1'b0, 32'h00012340);
        alu("add_r4", 3'd0, 4'd4, 4'd3, 4'd3, 16'h0, 1'b0, 5'd0,
            1'b0, 32'h00024680);
        rdreg("rd_r3", 4'd3);
        rdreg("rd_r4", 4'd4);

        alu("mov_r3b", 3'd5, 4'd3, 4'd0, 4'd0, 16'h0100, 1'b1, 5'd0,
            1'b0, 32'h100);
        alu("mov_r4b", 3'd5, 4'd4, 4'd0, 4'd0, 16'h55AA, 1'b1, 5'd0,
            1'b0, 32'h55AA);
        mem("load", 2'd1, 4'd5, 4'd3, 16'h8, 3, 32'hDEADBEEF, 32'h108);
        rdreg("rd_r5", 4'd5);
        mem("store", 2'd2, 4'd4, 4'd3, 16'h0, 2, 32'h12345678, 32'h100);
        rdreg("rd_r4_st", 4'd4);
        rdreg("rd_r3_st", 4'd3);

        alu("mov_r1", 3'd5, 4'd1, 4'd0, 4'd0, 16'd5, 1'b1, 5'd0,
            1'b0, 32'd5);
        alu("sub_eq", 3'd1, 4'd2, 4'd1, 4'd0, 16'd5, 1'b1, 5'd0,
            1'b1, 32'd0);
        chk("flags_sub_eq", 32'(flags), FE ? 32'h6 : 32'h0);
        branch("br_z", 2'd1, 4'd0, 16'h40, 1'b1, 32'h40);
        branch("br_nz", 2'd2, 4'd0, 16'h80, !FE, 32'h80);

        alu("mov_r6", 3'd5, 4'd6, 4'd0, 4'd0, 16'hFFFF, 1'b1, 5'd0,
            1'b0, 32'h0000FFFF);
        alu("mov_r7", 3'd5, 4'd7, 4'd0, 4'd0, 16'hFFFF, 1'b1, 5'd16,
            1'b0, 32'hFFFF0000);
        alu("or_r6", 3'd3, 4'd6, 4'd6, 4'd7, 16'h0, 1'b0, 5'd0,
            1'b0, 32'hFFFFFFFF);
        alu("add_wrap", 3'd0, 4'd8, 4'd6, 4'd0, 16'd1, 1'b1, 5'd0,
            1'b1, 32'd0);
        chk("flags_wrap", 32'(flags), FE ? 32'h6 : 32'h0);
        alu("adc", 3'd6, 4'd11, 4'd0, 4'd0, 16'd0, 1'b1, 5'd0,
            1'b0, FE ? 32'd1 : 32'd0);

        alu("mov_r9", 3'd5, 4'd9, 4'd0, 4'd0, 16'h7FFF, 1'b1, 5'd16,
            1'b0, 32'h7FFF0000);
        alu("or_r9", 3'd3, 4'd9, 4'd9, 4'd0, 16'hFFFF, 1'b1, 5'd0,
            1'b0, 32'h7FFFFFFF);
        alu("add_ovf", 3'd0, 4'd10, 4'd9, 4'd0, 16'd1, 1'b1, 5'd0,
            1'b1, 32'h80000000);
        chk("flags_ovf", 32'(flags), FE ? 32'h9 : 32'h0);

        alu("mov_sh20", 3'd5, 4'd12, 4'd0, 4'd0, 16'hFFFF, 1'b1, 5'd20,
            1'b0, 32'hFFF00000);
        alu("xor", 3'd4, 4'd13, 4'd12, 4'd6, 16'h0, 1'b0, 5'd0,
            1'b0, 32'h000FFFFF);
        alu("and", 3'd2, 4'd14, 4'd13, 4'd0, 16'hF0F0, 1'b1, 5'd0,
            1'b0, 32'h0000F0F0);
        alu("sub_brw", 3'd1, 4'd15, 4'd1, 4'd0, 16'd7, 1'b1, 5'd0,
            1'b1, 32'hFFFFFFFE);
        chk("flags_brw", 32'(flags), FE ? 32'h8 : 32'h0);
        branch("br_c", 2'd3, 4'd3, 16'h10, !FE, 32'h110);
        alu("sbc", 3'd7, 4'd2, 4'd1, 4'd0, 16'd1, 1'b1, 5'd0,
            1'b0, 32'd3);

        rdreg("rd_r2", 4'd2);
        rdreg("rd_r6", 4'd6);
        rdreg("rd_r8", 4'd8);
        rdreg("rd_r10", 4'd10);
        rdreg("rd_r11", 4'd11);
        rdreg("rd_r12", 4'd12);
        rdreg("rd_r13", 4'd13);
        rdreg("rd_r14", 4'd14);
        rdreg("rd_r15", 4'd15);

        sb.push_back(mreq_t'{32'h104, 1'b0, m[5]});
        issue(2'd1, 3'd0, 5'd0, 16'h4, 1'b1, 1'b0, 2'd0,
              4'd5, 4'd3, 4'd0);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (reqm) break;
        end
        chk("abort_reqm_seen", 32'(reqm), 32'd1);
        chk("abort_sb_avail", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("abort_addr", addr, e.a);
            chk("abort_rw", 32'(rw), 32'(e.w));
        end
        @(negedge clk);
        chk("abort_mwait_reqm", 32'(reqm), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_reqm_async", 32'(reqm), 32'd0);
        chk("abort_flush", 32'(flush), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        @(negedge clk);
        foreach (m[i]) m[i] = 32'd0;
        rdreg("clr_r3", 4'd3);
        rdreg("clr_r4", 4'd4);
        rdreg("clr_r5", 4'd5);
        rdreg("clr_r10", 4'd10);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
